// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text-line path.
package vga_text_pkg;

  localparam int N_CHARS_DEF = 41;

  localparam logic [7:0] CH_BLANK    = 8'd0;
  localparam logic [7:0] CH_BS       = 8'd8;
  localparam logic [7:0] CH_FF       = 8'd12;
  localparam logic [7:0] CH_CR       = 8'd13;
  localparam logic [7:0] CH_PRINT_LO = 8'd32;
  localparam logic [7:0] CH_PRINT_HI = 8'd126;

  typedef enum logic {IDLE, CLEAR} buf_state_t;

endpackage

// File: rtl/char_buffer_ctrl_if.sv
// Byte-wide valid/ready write channel from a character source into the text buffer.
interface char_buffer_ctrl_if;

  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;

  modport master (output wr_valid, output wr_char, input wr_ready);
  modport slave  (input wr_valid, input wr_char, output wr_ready);

endinterface

// File: rtl/vsync_edge_detect.sv
// Registers vsync and flags its falling edge for one cycle; reusable by any frame-synchronous block.
module vsync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vsync_i,
  output logic vs_fall_o
);

  logic vsync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync_i;
    end
  end

  assign vs_fall_o = vsync_q & ~vsync_i;

endmodule

// File: rtl/char_buffer_ctrl.sv
// Editable shadow line with cursor, committed to the display array on vsync fall; byte effects land next cycle.
// Accepts one byte per cycle in IDLE; wr_ready drops for the N_CHARS cycles of a form-feed clear.
module char_buffer_ctrl
  import vga_text_pkg::*;
#(
  parameter int N_CHARS = N_CHARS_DEF,
  parameter int POS_W   = 6
) (
  input  logic               clock_25,
  input  logic               reset,
  input  logic               vsync,
  char_buffer_ctrl_if.slave  wr,
  output logic [0:7]         char [0:N_CHARS-1],
  output logic [POS_W-1:0]   cursor_pos,
  output logic               busy
);

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(N_CHARS - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  buf_state_t       state_q, state_d;
  logic [POS_W-1:0] cursor_q, cursor_d;
  logic [POS_W-1:0] clr_idx_q, clr_idx_d;
  logic             dirty_q, dirty_d;
  logic [0:7]       shadow_q [0:N_CHARS-1];
  logic [0:7]       char_q   [0:N_CHARS-1];

  logic             sh_we;
  logic [POS_W-1:0] sh_idx;
  logic [0:7]       sh_dat;
  logic             vs_fall;
  logic             accept;
  logic             commit;

  vsync_edge_detect u_vs_edge (
    .clk_i     (clock_25),
    .rst_i     (reset),
    .vsync_i   (vsync),
    .vs_fall_o (vs_fall)
  );

  assign wr.wr_ready = (state_q == IDLE) && !reset;
  assign accept      = wr.wr_valid && wr.wr_ready;
  // The copy takes the pre-write shadow; a write in the same cycle re-arms dirty below.
  assign commit      = vs_fall && dirty_q && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    clr_idx_d = clr_idx_q;
    dirty_d   = commit ? 1'b0 : dirty_q;
    sh_we     = 1'b0;
    sh_idx    = cursor_q;
    sh_dat    = CH_BLANK;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wr.wr_char >= CH_PRINT_LO && wr.wr_char <= CH_PRINT_HI) begin
            sh_we    = 1'b1;
            sh_dat   = wr.wr_char;
            cursor_d = (cursor_q == LAST_IDX) ? '0 : cursor_q + POS_ONE;
            dirty_d  = 1'b1;
          end else if (wr.wr_char == CH_BS) begin
            if (cursor_q != '0) begin
              cursor_d = cursor_q - POS_ONE;
              sh_we    = 1'b1;
              sh_idx   = cursor_q - POS_ONE;
              dirty_d  = 1'b1;
            end
          end else if (wr.wr_char == CH_CR) begin
            cursor_d = '0;
          end else if (wr.wr_char == CH_FF) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
          end
        end
      end
      CLEAR: begin
        sh_we  = 1'b1;
        sh_idx = clr_idx_q;
        if (clr_idx_q == LAST_IDX) begin
          clr_idx_d = '0;
          cursor_d  = '0;
          dirty_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + POS_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q   <= IDLE;
      cursor_q  <= '0;
      clr_idx_q <= '0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      clr_idx_q <= clr_idx_d;
      dirty_q   <= dirty_d;
    end
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      for (int i = 0; i < N_CHARS; i++) begin
        shadow_q[i] <= CH_BLANK;
        char_q[i]   <= CH_BLANK;
      end
    end else begin
      if (sh_we) begin
        shadow_q[sh_idx] <= sh_dat;
      end
      if (commit) begin
        for (int i = 0; i < N_CHARS; i++) begin
          char_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign char       = char_q;
  assign cursor_pos = cursor_q;
  assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Directed bench for char_buffer_ctrl: hand-computed display contents after each edit/commit sequence.
module tb_char_buffer_ctrl;

  localparam int N     = 41;
  localparam int POS_W = 6;

  logic             clock_25 = 1'b0;
  logic             reset;
  logic             vsync;
  logic [0:7]       char_w [0:N-1];
  logic [POS_W-1:0] cursor_pos;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp [0:N-1];

  char_buffer_ctrl_if wr ();

  char_buffer_ctrl #(.N_CHARS(N), .POS_W(POS_W)) dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .vsync      (vsync),
    .wr         (wr),
    .char       (char_w),
    .cursor_pos (cursor_pos),
    .busy       (busy)
  );

  always #20 clock_25 = ~clock_25;

  task automatic tick();
    @(posedge clock_25);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr.wr_valid = 1'b1;
    wr.wr_char  = b;
    tick();
    wr.wr_valid = 1'b0;
  endtask

  // Falling edge is seen on the first tick; vsync returns high before the next edge.
  task automatic vsync_fall();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
  endtask

  task automatic set_exp_all(input logic [7:0] v);
    for (int i = 0; i < N; i++) exp[i] = v;
  endtask

  function automatic logic [N*8-1:0] pack_dut();
    logic [N*8-1:0] v;
    for (int i = 0; i < N; i++) v[8*(N-1-i) +: 8] = char_w[i];
    return v;
  endfunction

  function automatic logic [N*8-1:0] pack_exp();
    logic [N*8-1:0] v;
    for (int i = 0; i < N; i++) v[8*(N-1-i) +: 8] = exp[i];
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (wr.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low got %b exp 0", wr.wr_ready);
    end
    checks++;
    if (cursor_pos !== 6'd0) begin
      errors++;
      $display("FAIL reset_cursor got %0d exp 0", cursor_pos);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (wr.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after got %b exp 1", wr.wr_ready);
    end
    set_exp_all(8'd0);
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL reset_char got %h exp %h", pack_dut(), pack_exp());
    end
  endtask

  task automatic test_basic();
    send_byte(8'd48);
    send_byte(8'd49);
    send_byte(8'd50);
    checks++;
    if (cursor_pos !== 6'd3) begin
      errors++;
      $display("FAIL basic_cursor got %0d exp 3", cursor_pos);
    end
    set_exp_all(8'd0);
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL basic_nocommit got %h exp %h", pack_dut(), pack_exp());
    end
    vsync_fall();
    exp[0] = 8'd48;
    exp[1] = 8'd49;
    exp[2] = 8'd50;
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL basic_commit got %h exp %h", pack_dut(), pack_exp());
    end
    tick();
  endtask

  task automatic test_wrap();
    send_byte(8'd13);
    checks++;
    if (cursor_pos !== 6'd0) begin
      errors++;
      $display("FAIL cr_cursor got %0d exp 0", cursor_pos);
    end
    for (int i = 0; i < N; i++) send_byte(8'd65);
    checks++;
    if (cursor_pos !== 6'd0) begin
      errors++;
      $display("FAIL wrap_cursor got %0d exp 0", cursor_pos);
    end
    send_byte(8'd66);
    vsync_fall();
    set_exp_all(8'd65);
    exp[0] = 8'd66;
    checks++;
    if (cursor_pos !== 6'd1) begin
      errors++;
      $display("FAIL wrap_cursor_b got %0d exp 1", cursor_pos);
    end
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL wrap_char got %h exp %h", pack_dut(), pack_exp());
    end
    tick();
  endtask

  task automatic test_backspace();
    send_byte(8'd13);
    send_byte(8'd8);
    checks++;
    if (cursor_pos !== 6'd0) begin
      errors++;
      $display("FAIL bs_at_zero_cursor got %0d exp 0", cursor_pos);
    end
    // Nothing dirty: a frame edge must leave the display alone.
    vsync_fall();
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL bs_at_zero_char got %h exp %h", pack_dut(), pack_exp());
    end
    tick();
    send_byte(8'd65);
    send_byte(8'd66);
    send_byte(8'd8);
    checks++;
    if (cursor_pos !== 6'd1) begin
      errors++;
      $display("FAIL bs_cursor got %0d exp 1", cursor_pos);
    end
    vsync_fall();
    set_exp_all(8'd65);
    exp[1] = 8'd0;
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL bs_char got %h exp %h", pack_dut(), pack_exp());
    end
    tick();
  endtask

  task automatic test_clear();
    int n;
    send_byte(8'd13);
    for (int i = 0; i < 10; i++) send_byte(8'd97 + 8'(i));
    checks++;
    if (cursor_pos !== 6'd10) begin
      errors++;
      $display("FAIL clear_fill_cursor got %0d exp 10", cursor_pos);
    end
    wr.wr_valid = 1'b1;
    wr.wr_char  = 8'd12;
    tick();
    wr.wr_char  = 8'd88;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      checks++;
      if (wr.wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL clear_ready_low cycle %0d got %b exp 0", n, wr.wr_ready);
      end
      if (n == 10) vsync = 1'b0;
      if (n == 11) vsync = 1'b1;
      tick();
    end
    checks++;
    if (n !== 41) begin
      errors++;
      $display("FAIL clear_busy_cycles got %0d exp 41", n);
    end
    checks++;
    if (wr.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_ready_back got %b exp 1", wr.wr_ready);
    end
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL clear_vsync_nocopy got %h exp %h", pack_dut(), pack_exp());
    end
    tick();
    wr.wr_valid = 1'b0;
    checks++;
    if (cursor_pos !== 6'd1) begin
      errors++;
      $display("FAIL clear_x_cursor got %0d exp 1", cursor_pos);
    end
    vsync_fall();
    set_exp_all(8'd0);
    exp[0] = 8'd88;
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL clear_commit got %h exp %h", pack_dut(), pack_exp());
    end
    tick();
  endtask

  task automatic test_same_cycle();
    send_byte(8'd68);
    wr.wr_valid = 1'b1;
    wr.wr_char  = 8'd67;
    vsync       = 1'b0;
    tick();
    wr.wr_valid = 1'b0;
    vsync       = 1'b1;
    exp[1] = 8'd68;
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL same_cycle_excl got %h exp %h", pack_dut(), pack_exp());
    end
    checks++;
    if (cursor_pos !== 6'd3) begin
      errors++;
      $display("FAIL same_cycle_cursor got %0d exp 3", cursor_pos);
    end
    tick();
    vsync_fall();
    exp[2] = 8'd67;
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL same_cycle_next got %h exp %h", pack_dut(), pack_exp());
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    send_byte(8'd12);
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_clr_busy_before got %b exp 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    set_exp_all(8'd0);
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL rst_clr_char got %h exp %h", pack_dut(), pack_exp());
    end
    checks++;
    if (cursor_pos !== 6'd0) begin
      errors++;
      $display("FAIL rst_clr_cursor got %0d exp 0", cursor_pos);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_clr_busy got %b exp 0", busy);
    end
    checks++;
    if (wr.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_clr_ready got %b exp 1", wr.wr_ready);
    end
    // Shadow cell 2 still held 'C' before reset; it must come back blank.
    tick();
    send_byte(8'd90);
    vsync_fall();
    exp[0] = 8'd90;
    checks++;
    if (pack_dut() !== pack_exp()) begin
      errors++;
      $display("FAIL rst_clr_shadow got %h exp %h", pack_dut(), pack_exp());
    end
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    vsync       = 1'b1;
    wr.wr_valid = 1'b0;
    wr.wr_char  = 8'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_backspace();
    test_clear();
    test_same_cycle();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
